// File: rtl/ctrl_regfile_pkg.sv
// Shared constants for the multi-channel move-generator control register file:
// default widths, register offsets, AXI response codes, status bit indices.
package ctrl_regfile_pkg;

    localparam int DEF_SIDE_WIDTH     = 8;
    localparam int DEF_MAX_POSITIONS  = 256;
    localparam int DEF_MOVE_IDX_WIDTH = $clog2(DEF_MAX_POSITIONS);
    localparam int DEF_EVAL_WIDTH     = 24;

    localparam logic [7:0] REG_CTRL       = 8'h00;
    localparam logic [7:0] REG_MOVE_IDX   = 8'h01;
    localparam logic [7:0] REG_POS        = 8'h02;
    localparam logic [7:0] REG_RANK0      = 8'h08;
    localparam logic [7:0] REG_RANK7      = 8'h0F;
    localparam logic [7:0] REG_STATUS     = 8'h20;
    localparam logic [7:0] REG_STICKY     = 8'h21;
    localparam logic [7:0] REG_MOVE_COUNT = 8'h22;
    localparam logic [7:0] REG_EVAL       = 8'h23;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int ST_CAPTURE     = 0;
    localparam int ST_MOVES_READY = 1;
    localparam int ST_MOVE_READY  = 2;
    localparam int ST_IDLE        = 3;
    localparam int ST_STALEMATE   = 4;
    localparam int ST_MATE        = 5;
    localparam int ST_THRICE      = 6;
    localparam int ST_FIFTY       = 7;

    function automatic logic reg_mapped(input logic [7:0] r);
        return (r == REG_CTRL) || (r == REG_MOVE_IDX) || (r == REG_POS) ||
               (r >= REG_RANK0 && r <= REG_RANK7) ||
               (r >= REG_STATUS && r <= REG_EVAL);
    endfunction

    function automatic logic [31:0] merge_strb(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [3:0]  s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = s[b] ? wd[b*8 +: 8] : old[b*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/ctrl_regfile_mc_if.sv
// AXI4-lite bus bundle (40-bit address, 32-bit data) between the PS port and
// the register file. master drives AW/W/AR and the ready for B/R; slave the rest.
interface ctrl_regfile_mc_if;

    logic [39:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [39:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/ctrl_chan_regs.sv
// One channel's registers: CTRL pulses/soft_reset, MOVE_IDX, POS and board
// staging with atomic commit, W1C sticky status, and the read-data mux.
// Ports: wr_* one-cycle write strobe (already decoded), rd_reg/rd_data read
// mux, engine-side outputs (board/pos/index/pulses) and status inputs.
module ctrl_chan_regs
    import ctrl_regfile_pkg::*;
#(
    parameter int SIDE_WIDTH     = DEF_SIDE_WIDTH,
    parameter int MOVE_IDX_WIDTH = DEF_MOVE_IDX_WIDTH,
    parameter int EVAL_WIDTH     = DEF_EVAL_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [7:0]                wr_reg,
    input  logic [31:0]               wr_data,
    input  logic [3:0]                wr_strb,
    input  logic [7:0]                rd_reg,
    output logic [31:0]               rd_data,
    output logic [8*SIDE_WIDTH-1:0]   board_out,
    output logic [8:0]                pos_out,
    output logic [MOVE_IDX_WIDTH-1:0] move_index_out,
    output logic                      new_board_valid,
    output logic                      clear_moves,
    output logic                      soft_reset,
    input  logic [7:0]                status_in,
    input  logic [MOVE_IDX_WIDTH-1:0] move_count_in,
    input  logic [EVAL_WIDTH-1:0]     eval_in
);

    logic [SIDE_WIDTH-1:0]   rank_q [8];
    logic [8*SIDE_WIDTH-1:0] board_nx;
    logic [8:0]              pos_q;
    logic [1:0]              lvl, edge_q, rise, w1c, sticky_q;
    logic                    wr_ctrl, commit, clr_mv;

    assign lvl     = {status_in[ST_MOVE_READY], status_in[ST_MOVES_READY]};
    assign rise    = lvl & ~edge_q;
    assign wr_ctrl = wr_en && (wr_reg == REG_CTRL);
    assign commit  = wr_ctrl && wr_strb[0] && wr_data[0];
    assign clr_mv  = wr_ctrl && wr_strb[0] && wr_data[1];
    assign w1c     = (wr_en && wr_reg == REG_STICKY && wr_strb[0]) ?
                     wr_data[1:0] : 2'b00;

    always_comb begin
        board_nx = '0;
        for (int r = 0; r < 8; r++)
            board_nx[r*SIDE_WIDTH +: SIDE_WIDTH] = rank_q[r];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 8; r++)
                rank_q[r] <= '0;
            pos_q           <= '0;
            move_index_out  <= '0;
            board_out       <= '0;
            pos_out         <= '0;
            new_board_valid <= 1'b0;
            clear_moves     <= 1'b0;
            soft_reset      <= 1'b0;
            edge_q          <= '0;
            sticky_q        <= '0;
        end else begin
            edge_q          <= lvl;
            // a fresh rise wins over a clear landing on the same edge
            sticky_q        <= (sticky_q & ~w1c) | rise;
            new_board_valid <= commit;
            clear_moves     <= clr_mv;
            if (commit) begin
                board_out <= board_nx;
                pos_out   <= pos_q;
            end
            if (wr_ctrl && wr_strb[3])
                soft_reset <= wr_data[31];
            if (wr_en && wr_reg == REG_MOVE_IDX)
                move_index_out <= MOVE_IDX_WIDTH'(
                    merge_strb(32'(move_index_out), wr_data, wr_strb));
            if (wr_en && wr_reg == REG_POS)
                pos_q <= 9'(merge_strb(32'(pos_q), wr_data, wr_strb));
            if (wr_en && wr_reg[7:3] == 5'b00001)
                rank_q[wr_reg[2:0]] <= SIDE_WIDTH'(
                    merge_strb(32'(rank_q[wr_reg[2:0]]), wr_data, wr_strb));
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_reg)
            REG_CTRL:       rd_data = {soft_reset, 31'b0};
            REG_MOVE_IDX:   rd_data = 32'(move_index_out);
            REG_POS:        rd_data = 32'(pos_q);
            REG_STATUS:     rd_data = 32'(status_in);
            REG_STICKY:     rd_data = 32'(sticky_q);
            REG_MOVE_COUNT: rd_data = 32'(move_count_in);
            REG_EVAL:       rd_data = 32'(signed'(eval_in));
            default:
                if (rd_reg[7:3] == 5'b00001)
                    rd_data = 32'(rank_q[rd_reg[2:0]]);
        endcase
    end

endmodule

// File: rtl/ctrl_regfile_mc.sv
// AXI4-lite register file for NUM_CHAN move-generator channels: address
// decode, single-outstanding write and read handshakes, SLVERR on bad access.
// Ports: clk/reset, axi (slave), per-channel engine outputs and status inputs
// flattened as NUM_CHAN concatenated slices, channel 0 in the low bits.
module ctrl_regfile_mc
    import ctrl_regfile_pkg::*;
#(
    parameter int NUM_CHAN       = 4,
    parameter int SIDE_WIDTH     = DEF_SIDE_WIDTH,
    parameter int MOVE_IDX_WIDTH = DEF_MOVE_IDX_WIDTH,
    parameter int EVAL_WIDTH     = DEF_EVAL_WIDTH,
    localparam int BOARD_WIDTH   = 8*SIDE_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset,
    ctrl_regfile_mc_if.slave                   axi,
    output logic [NUM_CHAN*BOARD_WIDTH-1:0]    board_out,
    output logic [NUM_CHAN*9-1:0]              pos_out,
    output logic [NUM_CHAN*MOVE_IDX_WIDTH-1:0] move_index_out,
    output logic [NUM_CHAN-1:0]                new_board_valid,
    output logic [NUM_CHAN-1:0]                clear_moves,
    output logic [NUM_CHAN-1:0]                soft_reset,
    input  logic [NUM_CHAN*8-1:0]              status_in,
    input  logic [NUM_CHAN*MOVE_IDX_WIDTH-1:0] move_count_in,
    input  logic [NUM_CHAN*EVAL_WIDTH-1:0]     eval_in
);

    logic [5:0]  wchan, rchan;
    logic [7:0]  wreg, rreg;
    logic        wok, rok, wr_fire, rd_fire;
    logic        bvalid_q, rvalid_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q, rsel;
    logic [31:0] ch_rdata [NUM_CHAN];
    logic        unused_addr;

    // word address w = addr[15:2]: channel in w[13:8], register in w[7:0]
    assign wchan = axi.awaddr[15:10];
    assign wreg  = axi.awaddr[9:2];
    assign rchan = axi.araddr[15:10];
    assign rreg  = axi.araddr[9:2];
    assign unused_addr = ^{axi.awaddr[39:16], axi.awaddr[1:0],
                           axi.araddr[39:16], axi.araddr[1:0]};

    assign wok = ({26'b0, wchan} < 32'(NUM_CHAN)) && reg_mapped(wreg);
    assign rok = ({26'b0, rchan} < 32'(NUM_CHAN)) && reg_mapped(rreg);

    assign wr_fire = axi.awvalid && axi.wvalid && !bvalid_q;
    assign rd_fire = axi.arvalid && !rvalid_q;

    assign axi.awready = wr_fire;
    assign axi.wready  = wr_fire;
    assign axi.arready = !rvalid_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rresp   = rresp_q;
    assign axi.rdata   = rdata_q;

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        ctrl_chan_regs #(
            .SIDE_WIDTH     (SIDE_WIDTH),
            .MOVE_IDX_WIDTH (MOVE_IDX_WIDTH),
            .EVAL_WIDTH     (EVAL_WIDTH)
        ) u_regs (
            .clk             (clk),
            .reset           (reset),
            .wr_en           (wr_fire && wok && (wchan == 6'(c))),
            .wr_reg          (wreg),
            .wr_data         (axi.wdata),
            .wr_strb         (axi.wstrb),
            .rd_reg          (rreg),
            .rd_data         (ch_rdata[c]),
            .board_out       (board_out[c*BOARD_WIDTH +: BOARD_WIDTH]),
            .pos_out         (pos_out[c*9 +: 9]),
            .move_index_out  (move_index_out[c*MOVE_IDX_WIDTH +: MOVE_IDX_WIDTH]),
            .new_board_valid (new_board_valid[c]),
            .clear_moves     (clear_moves[c]),
            .soft_reset      (soft_reset[c]),
            .status_in       (status_in[c*8 +: 8]),
            .move_count_in   (move_count_in[c*MOVE_IDX_WIDTH +: MOVE_IDX_WIDTH]),
            .eval_in         (eval_in[c*EVAL_WIDTH +: EVAL_WIDTH])
        );
    end

    always_comb begin
        rsel = '0;
        for (int c = 0; c < NUM_CHAN; c++)
            if (rchan == 6'(c))
                rsel = ch_rdata[c];
    end

    // read mux samples registers before this edge's write lands,
    // so a same-cycle read returns the old value
    always_ff @(posedge clk) begin
        if (reset) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            if (wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wok ? RESP_OKAY : RESP_SLVERR;
            end else if (axi.bready) begin
                bvalid_q <= 1'b0;
            end
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rresp_q  <= rok ? RESP_OKAY : RESP_SLVERR;
                rdata_q  <= rok ? rsel : 32'b0;
            end else if (axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule
